// File: rtl/sar_search_controller.sv
// Successive-approximation search controller: drives trial values onto a magnitude
// comparator and resolves the unknown operand MSB-first, exiting early on equality.
module sar_search_controller #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             aeqb,
    input  logic             agtb,
    input  logic             altb,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] found,
    output logic             err
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_guess, w_guess_nxt;
    logic [WIDTH-1:0] r_found, w_found_nxt;
    logic [KW-1:0]    r_k,     w_k_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;
    logic             r_err,   w_err_nxt;
    logic             w_onehot;

    assign w_onehot = $onehot({aeqb, agtb, altb});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_guess <= '0;
            r_found <= '0;
            r_k     <= KW'(WIDTH - 1);
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_guess <= w_guess_nxt;
            r_found <= w_found_nxt;
            r_k     <= w_k_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_guess_nxt = r_guess;
        w_found_nxt = r_found;
        w_k_nxt     = r_k;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt              = PROBE;
                    w_guess_nxt              = '0;
                    w_guess_nxt[WIDTH-1]     = 1'b1;
                    w_k_nxt                  = KW'(WIDTH - 1);
                    w_found_nxt              = '0;
                    w_busy_nxt               = 1'b1;
                    w_done_nxt               = 1'b0;
                    w_err_nxt                = 1'b0;
                end
            end
            PROBE: begin
                if (!w_onehot) begin
                    w_err_nxt   = 1'b1;
                    w_found_nxt = '0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = DONE;
                end else if (aeqb) begin
                    w_found_nxt = r_guess;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = DONE;
                end else if (r_k == '0) begin
                    // Last bit: a too-high guess means bit 0 of b is clear.
                    w_found_nxt    = r_guess;
                    w_found_nxt[0] = altb;
                    w_done_nxt     = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = DONE;
                end else begin
                    if (agtb) w_guess_nxt[r_k] = 1'b0;
                    w_guess_nxt[r_k - KW'(1)] = 1'b1;
                    w_k_nxt = r_k - KW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign guess = r_guess;
    assign found = r_found;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: doc/sar_search_controller.md
Name: sar_search_controller

Overview:
- Successive-approximation search controller; the initiating end of the magnitude-comparator interface.
- Drives a trial value onto comparator input a.
- Consumes the comparator's aeqb/agtb/altb flags, where b is an unknown operand held outside this block.
- Resolves b MSB-first in at most WIDTH evaluations, with early exit on equality; used in lab datapaths for value search/ADC-style conversion.

Parameters:
WIDTH, 4, operand width in bits (>=2); matches the comparator width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new search; sampled on clk rising edge
aeqb  input  1  comparator flag: guess == b
agtb  input  1  comparator flag: guess > b
altb  input  1  comparator flag: guess < b
guess  output  WIDTH  trial value driven to comparator input a (registered)
busy  output  1  high while a search is in progress
done  output  1  high (level) when a search has finished; held until next accepted start
found  output  WIDTH  resolved value of b; valid when done=1 (registered)
err  output  1  high with done when the flags were not one-hot during the search

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, guess=0, found=0, busy=0, done=0, err=0, bit index=WIDTH-1. Reset mid-search abandons the search; no partial result is kept.
- States: IDLE, PROBE, DONE.
- IDLE/DONE: start=1 at an edge moves the block to PROBE and sets:
  - guess = 1<<(WIDTH-1), k = WIDTH-1, busy=1, done=0, err=0.
  - found is cleared to 0.
- PROBE: start is ignored. Comparator is combinational; flags are sampled at the edge after guess is driven. One evaluation per clk. At each edge, on the flags for the current guess:
  - aeqb only: found=guess, done=1, busy=0, go to DONE (early exit).
  - agtb only, k>0: guess = (guess with bit k cleared) with bit k-1 set; k=k-1.
  - altb only, k>0: guess = guess with bit k-1 set; k=k-1.
  - agtb only, k=0: found = guess with bit 0 cleared; go to DONE with done=1, busy=0.
  - altb only, k=0: found = guess; go to DONE with done=1, busy=0.
  - Flags not exactly one-hot (none set, or more than one set): err=1, found=0, done=1, busy=0, go to DONE.
- guess holds its last value in DONE and IDLE.
- Latency: start edge to done=1 is 1..WIDTH further edges. Exactly WIDTH edges when b is never hit exactly (e.g. b=0).
- done/err/found hold in DONE until the next accepted start, which clears them on that edge.
- No wrap-around: k never decrements below 0. Arithmetic is bitwise set/clear only; no adders.

Test Plan:
- Comparator model with b=5, pulse start:
  - guess sequence 8,4,6,5 on successive cycles.
  - done=1, found=5, err=0 at the 4th evaluation edge; busy=1 for exactly 4 cycles.
- b=8 -> first guess 8 hits aeqb; done=1, found=8 one edge after start; busy high for 1 cycle.
- b=0 -> guesses 8,4,2,1 all agtb; done=1, found=0, err=0 after 4 evaluations.
- b=15 -> guesses 8,12,14,15; eq at the 4th evaluation; found=15.
- b=11 -> guesses 8,12,10,11; found=11 after 4 evaluations.
- Fault injection: force aeqb=1 and agtb=1 on the 2nd evaluation -> err=1, done=1, found=0 at that edge.
- Robustness:
  - Re-pulse start mid-search: ignored, sequence unchanged.
  - Drop rst_n between clock edges mid-search: all outputs 0 immediately, state IDLE.
  - A new start after reset runs a full search correctly.
